// File: rtl/mouse_input_conditioner.sv
// Mouse button debouncer and saturating horizontal pointer tracker.
// Button and motion paths share only clock and reset.
module mouse_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned X_MAX           = 639
) (
    input  logic        clock,
    input  logic        reset_,
    input  logic        button_raw_,
    input  logic        delta_valid,
    input  logic [7:0]  delta_x,
    output logic        delta_ready,
    input  logic        recenter,
    output logic        mouse_pressed_,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic [15:0] mouse_x
);

    localparam logic [15:0] L_XMAX   = 16'(X_MAX);
    localparam logic [15:0] L_CENTER = 16'(X_MAX / 2);
    localparam logic [15:0] L_TERM   =
        16'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);
    localparam bit          L_DIRECT = (DEBOUNCE_CYCLES <= 1);

    typedef enum logic [1:0] {
        RELEASED,
        CHECK_PRESS,
        PRESSED,
        CHECK_RELEASE
    } state_t;

    logic        r_sync1;
    logic        r_sync2;
    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_pressed_;
    logic        r_press;
    logic        r_release;
    logic        r_ready;
    logic [15:0] r_x;

    logic               w_sample;
    logic               w_done;
    logic               w_xfer;
    logic signed [17:0] w_sum;
    logic signed [17:0] w_lim;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= button_raw_;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
    // The sample that enters a CHECK state is the first stable one.
    assign w_done   = (r_cnt == L_TERM);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state    <= RELEASED;
            r_cnt      <= '0;
            r_pressed_ <= 1'b1;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                RELEASED: begin
                    if (!w_sample) begin
                        r_cnt <= '0;
                        if (L_DIRECT) begin
                            r_state    <= PRESSED;
                            r_pressed_ <= 1'b0;
                            r_press    <= 1'b1;
                        end else begin
                            r_state <= CHECK_PRESS;
                        end
                    end
                end
                CHECK_PRESS: begin
                    if (w_sample) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (w_done) begin
                        r_state    <= PRESSED;
                        r_cnt      <= '0;
                        r_pressed_ <= 1'b0;
                        r_press    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                PRESSED: begin
                    if (w_sample) begin
                        r_cnt <= '0;
                        if (L_DIRECT) begin
                            r_state    <= RELEASED;
                            r_pressed_ <= 1'b1;
                            r_release  <= 1'b1;
                        end else begin
                            r_state <= CHECK_RELEASE;
                        end
                    end
                end
                CHECK_RELEASE: begin
                    if (!w_sample) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (w_done) begin
                        r_state    <= RELEASED;
                        r_cnt      <= '0;
                        r_pressed_ <= 1'b1;
                        r_release  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_xfer = delta_valid & r_ready;
    assign w_lim  = $signed({2'b00, L_XMAX});
    assign w_sum  = $signed({2'b00, r_x})
                  + $signed({{10{delta_x[7]}}, delta_x});

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_ready <= 1'b0;
            r_x     <= L_CENTER;
        end else begin
            r_ready <= 1'b1;
            // Recenter overrides and silently drops a coincident delta.
            if (recenter) begin
                r_x <= L_CENTER;
            end else if (w_xfer) begin
                if (w_sum < 18'sd0) begin
                    r_x <= '0;
                end else if (w_sum > w_lim) begin
                    r_x <= L_XMAX;
                end else begin
                    r_x <= w_sum[15:0];
                end
            end
        end
    end

    assign delta_ready    = r_ready;
    assign mouse_pressed_ = r_pressed_;
    assign press_pulse    = r_press;
    assign release_pulse  = r_release;
    assign mouse_x        = r_x;

endmodule

// File: tb/tb_mouse_input_conditioner.sv
// Scoreboard bench for mouse_input_conditioner with hand-timed vectors.
module tb_mouse_input_conditioner;

    localparam int DB = 4;
    localparam int XM = 639;

    logic        clock = 1'b0;
    logic        reset_;
    logic        button_raw_;
    logic        delta_valid;
    logic [7:0]  delta_x;
    logic        delta_ready;
    logic        recenter;
    logic        mouse_pressed_;
    logic        press_pulse;
    logic        release_pulse;
    logic [15:0] mouse_x;

    always #5 clock = ~clock;

    mouse_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .X_MAX(XM)
    ) dut (
        .clock(clock),
        .reset_(reset_),
        .button_raw_(button_raw_),
        .delta_valid(delta_valid),
        .delta_x(delta_x),
        .delta_ready(delta_ready),
        .recenter(recenter),
        .mouse_pressed_(mouse_pressed_),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .mouse_x(mouse_x)
    );

    typedef struct {
        logic [15:0] x;
        logic        pr;
        logic        pp;
        logic        rp;
        logic        rdy;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: outputs after each rising edge are compared to the queue head.
    always @(posedge clock) begin
        #1;
        n_chk++;
        if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
            n_fail++;
            $display("FAIL pulse_overlap: got 1/1 expected not both");
        end
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk({m_e.tag, ".x"}, mouse_x, m_e.x);
            chk({m_e.tag, ".pressed_"}, {15'd0, mouse_pressed_}, {15'd0, m_e.pr});
            chk({m_e.tag, ".press_pulse"}, {15'd0, press_pulse}, {15'd0, m_e.pp});
            chk({m_e.tag, ".release_pulse"}, {15'd0, release_pulse}, {15'd0, m_e.rp});
            chk({m_e.tag, ".ready"}, {15'd0, delta_ready}, {15'd0, m_e.rdy});
        end
    end

    task automatic step(input logic rst, input logic b, input logic v,
                        input int d, input logic rc,
                        input logic [15:0] x, input logic pr,
                        input logic pp, input logic rp, input logic rdy,
                        input string tag);
        exp_t e;
        @(negedge clock);
        reset_      = rst;
        button_raw_ = b;
        delta_valid = v;
        delta_x     = 8'(d);
        recenter    = rc;
        e.x   = x;
        e.pr  = pr;
        e.pp  = pp;
        e.rp  = rp;
        e.rdy = rdy;
        e.tag = tag;
        q.push_back(e);
    endtask

    initial begin
        reset_      = 1'b0;
        button_raw_ = 1'b1;
        delta_valid = 1'b0;
        delta_x     = 8'd0;
        recenter    = 1'b0;

        step(0, 1, 0, 0, 0, 319, 1, 0, 0, 0, "rst0");
        step(0, 1, 1, 50, 0, 319, 1, 0, 0, 0, "rst_xfer");
        step(1, 1, 0, 0, 0, 319, 1, 0, 0, 1, "rdy_rise");

        step(1, 1, 1, 100, 0, 419, 1, 0, 0, 1, "d+100");
        step(1, 1, 1, 127, 0, 546, 1, 0, 0, 1, "d+127a");
        step(1, 1, 1, 127, 0, 639, 1, 0, 0, 1, "sat_hi");
        step(1, 1, 1, -128, 0, 511, 1, 0, 0, 1, "d-128a");
        step(1, 1, 1, -128, 0, 383, 1, 0, 0, 1, "d-128b");
        step(1, 1, 1, -128, 0, 255, 1, 0, 0, 1, "d-128c");
        step(1, 1, 1, -128, 0, 127, 1, 0, 0, 1, "d-128d");
        step(1, 1, 1, -128, 0, 0, 1, 0, 0, 1, "sat_lo");
        step(1, 1, 1, -128, 0, 0, 1, 0, 0, 1, "stay_lo");
        step(1, 1, 0, 50, 0, 0, 1, 0, 0, 1, "no_valid");
        step(1, 1, 1, 10, 0, 10, 1, 0, 0, 1, "d+10");
        step(1, 1, 1, 5, 1, 319, 1, 0, 0, 1, "recenter_wins");

        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 0, 0, 319, 1, 0, 0, 1, "press_wait");
        step(1, 0, 1, 5, 0, 324, 0, 1, 0, 1, "press_commit");
        step(1, 0, 0, 0, 0, 324, 0, 0, 0, 1, "press_after");

        for (int i = 0; i < 5; i++)
            step(1, 1, 0, 0, 0, 324, 0, 0, 0, 1, "rel_wait");
        step(1, 1, 0, 0, 0, 324, 1, 0, 1, 1, "rel_commit");
        step(1, 1, 0, 0, 0, 324, 1, 0, 0, 1, "rel_after");

        step(1, 0, 0, 0, 0, 324, 1, 0, 0, 1, "bounce0");
        step(1, 1, 0, 0, 0, 324, 1, 0, 0, 1, "bounce1");
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 0, 0, 324, 1, 0, 0, 1, "bounce_wait");
        step(1, 0, 0, 0, 0, 324, 0, 1, 0, 1, "bounce_commit");
        step(1, 0, 0, 0, 0, 324, 0, 0, 0, 1, "bounce_after");

        step(1, 0, 0, 0, 1, 319, 0, 0, 0, 1, "rc2");
        step(1, 0, 1, 127, 0, 446, 0, 0, 0, 1, "to600a");
        step(1, 0, 1, 127, 0, 573, 0, 0, 0, 1, "to600b");
        step(1, 0, 1, 27, 0, 600, 0, 0, 0, 1, "to600c");
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 0, 0, 600, 0, 0, 0, 1, "chkrel");

        step(0, 1, 1, 5, 0, 319, 1, 0, 0, 0, "rst_mid");
        #1;
        chk("async.x", mouse_x, 16'd319);
        chk("async.pressed_", {15'd0, mouse_pressed_}, 16'd1);
        chk("async.ready", {15'd0, delta_ready}, 16'd0);
        chk("async.release_pulse", {15'd0, release_pulse}, 16'd0);
        chk("async.press_pulse", {15'd0, press_pulse}, 16'd0);
        step(0, 1, 1, 5, 0, 319, 1, 0, 0, 0, "rst_hold");
        step(1, 1, 0, 0, 0, 319, 1, 0, 0, 1, "post_rst");
        for (int i = 0; i < 6; i++)
            step(1, 1, 0, 0, 0, 319, 1, 0, 0, 1, "post_rst_quiet");

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clock);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mouse_input_conditioner.md
MOUSE_INPUT_CONDITIONER -- requirements
Module: mouse_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized samples required to accept a button change; legal range 1..65535.
REQ-002 Parameter X_MAX, default 639, is the inclusive upper bound of mouse_x; legal range 1..65535.
REQ-003 Port clock  input  1  single block clock; all state updates on its rising edge.
REQ-004 Port reset_  input  1  reset, asynchronous assert, active-low.
REQ-005 Port button_raw_  input  1  raw mechanical button, active-low (0 = pressed), asynchronous to clock, may bounce.
REQ-006 Port delta_valid  input  1  delta_x carries a motion sample.
REQ-007 Port delta_x  input  8  signed two's-complement horizontal motion, range -128..+127.
REQ-008 Port delta_ready  output  1  block accepts a motion sample this cycle.
REQ-009 Port recenter  input  1  request to move mouse_x to the centre position.
REQ-010 Port mouse_pressed_  output  1  debounced button, active-low, registered.
REQ-011 Port press_pulse  output  1  one-cycle strobe on debounced press, registered.
REQ-012 Port release_pulse  output  1  one-cycle strobe on debounced release, registered.
REQ-013 Port mouse_x  output  16  unsigned pointer position, always within 0..X_MAX, registered.

Function
REQ-014 button_raw_ shall pass through a two-flop synchronizer before any other logic; no other logic shall sample button_raw_ directly.
REQ-015 The debounce FSM shall have states RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE.
REQ-016 RELEASED -> CHECK_PRESS when synced sample = 0; PRESSED -> CHECK_RELEASE when synced sample = 1; stability counter cleared on entry to either CHECK state.
REQ-017 In a CHECK state the counter shall increment each cycle the synced sample holds the new level; on the cycle it reaches DEBOUNCE_CYCLES the FSM shall commit (CHECK_PRESS -> PRESSED, CHECK_RELEASE -> RELEASED).
REQ-018 In a CHECK state, one synced sample back at the old level shall return the FSM to its previous stable state with the counter cleared and no output change.
REQ-019 Latency: a clean raw level change first sampled at edge N shall update mouse_pressed_ at edge N + 1 + DEBOUNCE_CYCLES.
REQ-020 press_pulse shall be 1 exactly in the cycle following the edge at which mouse_pressed_ falls; release_pulse likewise for the rise; never both 1; otherwise 0.
REQ-021 delta_ready shall be 1 in every cycle after reset release; a transfer occurs when delta_valid and delta_ready are both 1.
REQ-022 On a transfer, mouse_x at the next edge shall equal clamp(mouse_x + sign-extended delta_x, 0, X_MAX), computed with at least 18-bit signed intermediate so no wrap-around occurs.
REQ-023 Underflow below 0 shall saturate to 0; overflow above X_MAX shall saturate to X_MAX.
REQ-024 recenter = 1 shall load mouse_x with floor(X_MAX/2) at the next edge; simultaneous recenter and transfer: recenter wins, the delta is consumed and discarded.
REQ-025 Button and motion paths are independent; a press or release shall not affect mouse_x.

Reset
REQ-026 While reset_ = 0: synchronizer flops = 1, FSM = RELEASED, counter = 0, mouse_pressed_ = 1, press_pulse = 0, release_pulse = 0, delta_ready = 0, mouse_x = floor(X_MAX/2).
REQ-027 Reset asserted mid-operation (in a CHECK state or during a transfer) shall abandon it immediately; no pulse shall be emitted on reset assertion or deassertion.
REQ-028 delta_ready shall rise at the first rising clock edge after reset_ deasserts.

Verification
REQ-029 DEBOUNCE_CYCLES=4, button_raw_ 1->0 held clean, first sampled at edge 10 -> mouse_pressed_ = 0 after edge 15, press_pulse high for exactly one cycle after edge 15.
REQ-030 DEBOUNCE_CYCLES=4, raw press with bounce 0,1,0 at 1-cycle intervals then steady 0 -> FSM returns to RELEASED on the bounce, single press_pulse only after 4 stable synced samples.
REQ-031 X_MAX=639 after reset: mouse_x = 319; deltas +100, +127, +127 -> 419, 546, 639 (saturated); then -128 x6 -> ... 0, stays 0.
REQ-032 recenter and delta_valid with delta_x=+5 in the same cycle, mouse_x = 10 -> mouse_x = 319 next cycle, delta discarded.
REQ-033 reset_ pulled low in CHECK_RELEASE with mouse_x = 600 -> immediately mouse_pressed_ = 1, mouse_x = 319, delta_ready = 0, no release_pulse before or after deassertion.
REQ-034 Pressed then released cleanly -> exactly one press_pulse and one release_pulse, never overlapping.
